flappy_game_ctrl: RTL and testbench

Game-sequencing controller for the Flappy Bird VGA datapath. It owns the game state machine, bird vertical physics, collision latching and the BCD score. It drives the pipe renderer's run-enable and reset, the bird sprite's Y position, and the score shown on the seven-segment display. It sits beside the pixel-priority mux and is fed by the same hCount/vCount-derived pixel flags.

---
 rtl/flappy_pkg.sv | 32 +++
 rtl/flappy_game_ctrl_bcd_counter4.sv | 44 ++++
 rtl/flappy_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants for the Flappy Bird VGA datapath: game state encoding,
// screen geometry, palette and physics defaults.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BIRD_X   = 100;
    localparam int BIRD_W   = 16;
    localparam int BIRD_H   = 16;

    // 12-bit RGB (4:4:4) palette
    localparam logic [11:0] COLOR_SKY    = 12'h4CF;
    localparam logic [11:0] COLOR_PIPE   = 12'h0A0;
    localparam logic [11:0] COLOR_BIRD   = 12'hFE0;
    localparam logic [11:0] COLOR_GROUND = 12'hA72;
    localparam logic [11:0] COLOR_BLACK  = 12'h000;

    localparam int DEF_BIRD_Y_INIT  = 220;
    localparam int DEF_GRAVITY      = 1;
    localparam int DEF_FLAP_VEL     = -6;
    localparam int DEF_VMAX         = 8;
    localparam int DEF_Y_MAX        = SCREEN_H - BIRD_H;
    localparam int DEF_DEATH_FRAMES = 60;

endpackage

// File: rtl/flappy_game_ctrl_bcd_counter4.sv
// Four-digit BCD score counter: synchronous clear, increment enable,
// saturates at 9999.
module bcd_counter4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] r_count;
    logic [15:0] w_next;
    logic        w_carry;

    // Ripple a +1 through the digits, wrapping each 9 to 0 with carry
    always_comb begin
        w_next  = r_count;
        w_carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    // Count register: clear wins over increment; hold at 9999
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != 16'h9999)) begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencing controller: state machine, bird vertical physics,
// collision latch, pipe renderer control and BCD score.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int BIRD_Y_INIT  = DEF_BIRD_Y_INIT,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int FLAP_VEL     = DEF_FLAP_VEL,
    parameter int VMAX         = DEF_VMAX,
    parameter int Y_MAX        = DEF_Y_MAX,
    parameter int DEATH_FRAMES = DEF_DEATH_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_button,
    input  logic        frame_tick,
    input  logic        bright,
    input  logic        bird_px,
    input  logic        pipe_px,
    input  logic        pipe_passed,
    output logic        pipe_run_en,
    output logic        pipe_reset,
    output logic [9:0]  bird_y,
    output logic [15:0] score,
    output logic [1:0]  state,
    output logic        game_over
);

    localparam logic signed [5:0]  LP_GRAV   = 6'(GRAVITY);
    localparam logic signed [5:0]  LP_FLAP   = 6'(FLAP_VEL);
    localparam logic signed [5:0]  LP_VMAX6  = 6'(VMAX);
    localparam logic signed [6:0]  LP_VMAX7  = 7'(VMAX);
    localparam logic signed [10:0] LP_YMAX11 = 11'(Y_MAX);
    localparam logic [9:0]         LP_YMAX10 = 10'(Y_MAX);
    localparam logic [9:0]         LP_YINIT  = 10'(BIRD_Y_INIT);
    localparam logic [5:0]         LP_DEATH  = 6'(DEATH_FRAMES);

    state_t             r_state;
    logic               r_btn_q;
    logic               r_pipe_run_en;
    logic               r_pipe_reset;
    logic               r_game_over;
    logic               r_hit;
    logic               r_flap;
    logic [9:0]         r_bird_y;
    logic signed [5:0]  r_vel;
    logic [5:0]         r_death_cnt;

    logic               w_press;
    logic               w_hit_now;
    logic               w_hit_any;
    logic               w_flap;
    logic signed [6:0]  w_vel_sum;
    logic signed [5:0]  w_vel_grav;
    logic signed [5:0]  w_vel_n;
    logic signed [10:0] w_y_n;
    logic [9:0]         w_y_clamp;
    logic [5:0]         w_death_next;
    logic               w_score_clr;
    logic               w_score_inc;

    assign w_press   = start_button & ~r_btn_q;
    assign w_hit_now = bright & bird_px & pipe_px;
    assign w_hit_any = r_hit | w_hit_now;
    // A press landing on the tick cycle still flaps at that tick
    assign w_flap    = r_flap | w_press;

    // Next-frame velocity and position, in widened signed arithmetic
    always_comb begin
        w_vel_sum  = {r_vel[5], r_vel} + {LP_GRAV[5], LP_GRAV};
        w_vel_grav = (w_vel_sum > LP_VMAX7) ? LP_VMAX6 : w_vel_sum[5:0];
        w_vel_n    = ((r_state == ST_PLAY) && w_flap) ? LP_FLAP : w_vel_grav;
        w_y_n      = $signed({1'b0, r_bird_y}) + {{5{w_vel_n[5]}}, w_vel_n};
        if (w_y_n < 0) begin
            w_y_clamp = '0;
        end else if (w_y_n >= LP_YMAX11) begin
            w_y_clamp = LP_YMAX10;
        end else begin
            w_y_clamp = w_y_n[9:0];
        end
        w_death_next = r_death_cnt + 6'd1;
    end

    // Game state machine with registered outputs and bird physics
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_btn_q       <= 1'b0;
            r_pipe_run_en <= 1'b0;
            r_pipe_reset  <= 1'b1;
            r_game_over   <= 1'b0;
            r_hit         <= 1'b0;
            r_flap        <= 1'b0;
            r_bird_y      <= LP_YINIT;
            r_vel         <= '0;
            r_death_cnt   <= '0;
        end else begin
            r_btn_q      <= start_button;
            r_pipe_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_pipe_run_en <= 1'b0;
                    r_game_over   <= 1'b0;
                    if (w_press) begin
                        r_state       <= ST_PLAY;
                        r_pipe_run_en <= 1'b1;
                        r_flap        <= 1'b1;
                        r_hit         <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_press)   r_flap <= 1'b1;
                    if (w_hit_now) r_hit  <= 1'b1;
                    if (frame_tick) begin
                        r_flap <= 1'b0;
                        if (w_hit_any || (w_y_n >= LP_YMAX11)) begin
                            r_state       <= ST_DYING;
                            r_pipe_run_en <= 1'b0;
                            r_death_cnt   <= '0;
                            r_bird_y      <= w_y_clamp;
                            r_vel         <= (w_y_n < 0) ? 6'sd0 : w_vel_n;
                        end else if (w_y_n < 0) begin
                            r_bird_y <= '0;
                            r_vel    <= '0;
                        end else begin
                            r_bird_y <= w_y_n[9:0];
                            r_vel    <= w_vel_n;
                        end
                    end
                end
                ST_DYING: begin
                    r_flap <= 1'b0;
                    if (frame_tick) begin
                        r_bird_y    <= w_y_clamp;
                        r_vel       <= (w_y_n < 0) ? 6'sd0 : w_vel_n;
                        r_death_cnt <= w_death_next;
                        if ((w_y_clamp == LP_YMAX10) || (w_death_next >= LP_DEATH)) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (w_press) begin
                        r_state      <= ST_IDLE;
                        r_game_over  <= 1'b0;
                        r_bird_y     <= LP_YINIT;
                        r_vel        <= '0;
                        r_pipe_reset <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_score_clr = (r_state == ST_IDLE) & w_press;
    assign w_score_inc = (r_state == ST_PLAY) & pipe_passed;

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (w_score_clr),
        .inc   (w_score_inc),
        .count (score)
    );

    assign pipe_run_en = r_pipe_run_en;
    assign pipe_reset  = r_pipe_reset;
    assign bird_y      = r_bird_y;
    assign state       = r_state;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed self-checking bench for flappy_game_ctrl.
module tb_flappy_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_button;
    logic        frame_tick;
    logic        bright;
    logic        bird_px;
    logic        pipe_px;
    logic        pipe_passed;
    logic        pipe_run_en;
    logic        pipe_reset;
    logic [9:0]  bird_y;
    logic [15:0] score;
    logic [1:0]  state;
    logic        game_over;

    int n_checks = 0;
    int n_fail   = 0;

    flappy_game_ctrl #(
        .BIRD_Y_INIT  (220),
        .GRAVITY      (1),
        .FLAP_VEL     (-6),
        .VMAX         (8),
        .Y_MAX        (464),
        .DEATH_FRAMES (60)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_button (start_button),
        .frame_tick   (frame_tick),
        .bright       (bright),
        .bird_px      (bird_px),
        .pipe_px      (pipe_px),
        .pipe_passed  (pipe_passed),
        .pipe_run_en  (pipe_run_en),
        .pipe_reset   (pipe_reset),
        .bird_y       (bird_y),
        .score        (score),
        .state        (state),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        start_button = 1'b1;
        step();
        start_button = 1'b0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (bird_y !== 10'd220) begin n_fail++; $display("FAIL reset_bird_y: got %0d want 220", bird_y); end
        n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL reset_score: got %h want 0000", score); end
        n_checks++; if (pipe_run_en !== 1'b0) begin n_fail++; $display("FAIL reset_run_en: got %b want 0", pipe_run_en); end
        n_checks++; if (pipe_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pipe_reset: got %b want 1", pipe_reset); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        reset = 1'b0;
        step();
        n_checks++; if (pipe_reset !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_reset_release: got %b want 0", pipe_reset); end
    endtask

    task automatic test_start();
        start_button = 1'b1;
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL start_state: got %0d want 1", state); end
        n_checks++; if (pipe_run_en !== 1'b1) begin n_fail++; $display("FAIL start_run_en: got %b want 1", pipe_run_en); end
        // holding the button must not generate further presses
        step();
        step();
        start_button = 1'b0;
        step();
        n_checks++; if (bird_y !== 10'd220) begin n_fail++; $display("FAIL start_bird_static: got %0d want 220", bird_y); end
    endtask

    task automatic test_score();
        for (int i = 0; i < 12; i++) begin
            pipe_passed = 1'b1;
            step();
            pipe_passed = 1'b0;
            step();
        end
        n_checks++; if (score !== 16'h0012) begin n_fail++; $display("FAIL score_12: got %h want 0012", score); end
    endtask

    task automatic test_physics();
        logic [9:0] exp_y [10] = '{10'd214, 10'd209, 10'd205, 10'd202, 10'd200,
                                   10'd199, 10'd199, 10'd200, 10'd202, 10'd205};
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (bird_y !== exp_y[i]) begin
                n_fail++;
                $display("FAIL physics_tick%0d: got %0d want %0d", i + 1, bird_y, exp_y[i]);
            end
        end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL physics_state: got %0d want 1", state); end
    endtask

    task automatic test_fall();
        int ticks = 0;
        while (state == 2'd1 && ticks < 100) begin
            tick();
            ticks++;
        end
        n_checks++; if (ticks != 34) begin n_fail++; $display("FAIL fall_ticks: got %0d want 34", ticks); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL fall_state: got %0d want 2", state); end
        n_checks++; if (bird_y !== 10'd464) begin n_fail++; $display("FAIL fall_floor_y: got %0d want 464", bird_y); end
        n_checks++; if (pipe_run_en !== 1'b0) begin n_fail++; $display("FAIL fall_run_en: got %b want 0", pipe_run_en); end
        pipe_passed = 1'b1;
        step();
        pipe_passed = 1'b0;
        step();
        n_checks++; if (score !== 16'h0012) begin n_fail++; $display("FAIL dying_pipe_passed: got %h want 0012", score); end
        press();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL dying_press_ignored: got %0d want 2", state); end
        tick();
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_state: got %0d want 3", state); end
        n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_game_over: got %b want 1", game_over); end
    endtask

    task automatic test_over_restart();
        start_button = 1'b1;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL restart_state: got %0d want 0", state); end
        n_checks++; if (bird_y !== 10'd220) begin n_fail++; $display("FAIL restart_bird_y: got %0d want 220", bird_y); end
        n_checks++; if (pipe_reset !== 1'b1) begin n_fail++; $display("FAIL restart_pipe_reset: got %b want 1", pipe_reset); end
        n_checks++; if (score !== 16'h0012) begin n_fail++; $display("FAIL restart_score_kept: got %h want 0012", score); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %b want 0", game_over); end
        start_button = 1'b0;
        step();
        n_checks++; if (pipe_reset !== 1'b0) begin n_fail++; $display("FAIL restart_pipe_reset_pulse: got %b want 0", pipe_reset); end
        pipe_passed = 1'b1;
        step();
        pipe_passed = 1'b0;
        step();
        n_checks++; if (score !== 16'h0012) begin n_fail++; $display("FAIL idle_pipe_passed: got %h want 0012", score); end
        start_button = 1'b1;
        step();
        n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL new_game_score: got %h want 0000", score); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL new_game_state: got %0d want 1", state); end
        start_button = 1'b0;
        step();
    endtask

    task automatic test_flap_same_tick();
        tick();
        tick();
        n_checks++; if (bird_y !== 10'd209) begin n_fail++; $display("FAIL flap_pre_y: got %0d want 209", bird_y); end
        start_button = 1'b1;
        frame_tick   = 1'b1;
        step();
        start_button = 1'b0;
        frame_tick   = 1'b0;
        step();
        n_checks++; if (bird_y !== 10'd203) begin n_fail++; $display("FAIL flap_same_tick_y: got %0d want 203", bird_y); end
        tick();
        n_checks++; if (bird_y !== 10'd198) begin n_fail++; $display("FAIL flap_after_y: got %0d want 198", bird_y); end
    endtask

    task automatic test_hit();
        int ticks = 0;
        bright = 1'b0; bird_px = 1'b1; pipe_px = 1'b1;
        step();
        bird_px = 1'b0; pipe_px = 1'b0;
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL hit_dark_state: got %0d want 1", state); end
        n_checks++; if (bird_y !== 10'd194) begin n_fail++; $display("FAIL hit_dark_y: got %0d want 194", bird_y); end
        bright = 1'b1; bird_px = 1'b1; pipe_px = 1'b1;
        step();
        bright = 1'b0; bird_px = 1'b0; pipe_px = 1'b0;
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL hit_wait_tick: got %0d want 1", state); end
        tick();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL hit_state: got %0d want 2", state); end
        n_checks++; if (bird_y !== 10'd191) begin n_fail++; $display("FAIL hit_y: got %0d want 191", bird_y); end
        n_checks++; if (pipe_run_en !== 1'b0) begin n_fail++; $display("FAIL hit_run_en: got %b want 0", pipe_run_en); end
        while (state == 2'd2 && ticks < 100) begin
            tick();
            ticks++;
        end
        n_checks++; if (ticks != 41) begin n_fail++; $display("FAIL dying_ticks: got %0d want 41", ticks); end
        n_checks++; if (bird_y !== 10'd464) begin n_fail++; $display("FAIL dying_floor_y: got %0d want 464", bird_y); end
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL dying_over: got %0d want 3", state); end
    endtask

    task automatic test_ceiling();
        press();
        press();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ceil_start: got %0d want 1", state); end
        for (int i = 0; i < 36; i++) begin
            start_button = 1'b1; frame_tick = 1'b1;
            step();
            start_button = 1'b0; frame_tick = 1'b0;
            step();
        end
        n_checks++; if (bird_y !== 10'd4) begin n_fail++; $display("FAIL ceil_pre_y: got %0d want 4", bird_y); end
        start_button = 1'b1; frame_tick = 1'b1;
        step();
        start_button = 1'b0; frame_tick = 1'b0;
        step();
        n_checks++; if (bird_y !== 10'd0) begin n_fail++; $display("FAIL ceil_y: got %0d want 0", bird_y); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL ceil_state: got %0d want 1", state); end
        tick();
        n_checks++; if (bird_y !== 10'd1) begin n_fail++; $display("FAIL ceil_vel_zero: got %0d want 1", bird_y); end
        tick();
        n_checks++; if (bird_y !== 10'd3) begin n_fail++; $display("FAIL ceil_fall: got %0d want 3", bird_y); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9999; i++) begin
            pipe_passed = 1'b1;
            step();
            pipe_passed = 1'b0;
            step();
        end
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL score_9999: got %h want 9999", score); end
        pipe_passed = 1'b1;
        step();
        pipe_passed = 1'b0;
        step();
        n_checks++; if (score !== 16'h9999) begin n_fail++; $display("FAIL score_saturate: got %h want 9999", score); end
    endtask

    task automatic test_reset_mid_play();
        bright = 1'b1; bird_px = 1'b1; pipe_px = 1'b1;
        step();
        bright = 1'b0; bird_px = 1'b0; pipe_px = 1'b0;
        press();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL midreset_state: got %0d want 0", state); end
        n_checks++; if (bird_y !== 10'd220) begin n_fail++; $display("FAIL midreset_bird_y: got %0d want 220", bird_y); end
        n_checks++; if (score !== 16'h0000) begin n_fail++; $display("FAIL midreset_score: got %h want 0000", score); end
        n_checks++; if (pipe_run_en !== 1'b0) begin n_fail++; $display("FAIL midreset_run_en: got %b want 0", pipe_run_en); end
        step();
        tick();
        n_checks++; if (bird_y !== 10'd220) begin n_fail++; $display("FAIL midreset_no_flap: got %0d want 220", bird_y); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL midreset_idle_hold: got %0d want 0", state); end
        press();
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL midreset_hit_cleared: got %0d want 1", state); end
        n_checks++; if (bird_y !== 10'd214) begin n_fail++; $display("FAIL midreset_new_flap: got %0d want 214", bird_y); end
    endtask

    initial begin
        reset        = 1'b1;
        start_button = 1'b0;
        frame_tick   = 1'b0;
        bright       = 1'b0;
        bird_px      = 1'b0;
        pipe_px      = 1'b0;
        pipe_passed  = 1'b0;
        test_reset();
        test_start();
        test_score();
        test_physics();
        test_fall();
        test_over_restart();
        test_flap_same_tick();
        test_hit();
        test_ceiling();
        test_saturation();
        test_reset_mid_play();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
